// File: rtl/irq_pkg.sv
// Shared constants and types for the pending-request arbiter and its encoder.
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Request/mask inputs and the valid/ack ID handshake between arbiter and consumer.
interface irq_pending_arbiter_if;
  import irq_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] mask;
  logic             irq_ack;
  logic             irq_valid;
  logic [ID_W-1:0]  irq_id;
  logic [N_REQ-1:0] pending;

  // The environment side drives requests, masks and acks.
  modport master (
    output req, mask, irq_ack,
    input  irq_valid, irq_id, pending
  );

  // The arbiter side.
  modport slave (
    input  req, mask, irq_ack,
    output irq_valid, irq_id, pending
  );

endinterface

// File: rtl/priority_encoder_8to3.sv
// Combinational 8-to-3 priority encoder; the highest set index wins.
module priority_encoder_8to3 (
  input  logic [7:0] i,
  output logic [2:0] out,
  output logic       valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    out   = '0;
    valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (i[k]) begin
        out   = 3'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Edge-triggered pending flags with masking, feeding a held valid/ack ID presentation.
module irq_pending_arbiter
  import irq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  irq_pending_arbiter_if.slave bus
);

  logic [N_REQ-1:0] req_d_q, req_d_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  arb_state_e       state_q, state_d;
  logic             irq_valid_q, irq_valid_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] cand;
  logic [ID_W-1:0]  enc_id;
  logic             enc_valid;
  logic             accept;

  assign rise   = bus.req & ~req_d_q;
  assign accept = (state_q == PRESENT) & bus.irq_ack;
  assign clr    = accept ? id_to_onehot(irq_id_q) : '0;
  assign cand   = pending_q & ~bus.mask;

  priority_encoder_8to3 u_enc (
    .i     (cand),
    .out   (enc_id),
    .valid (enc_valid)
  );

  always_comb begin
    req_d_d     = bus.req;
    // Set is OR-ed in after the clear so a coincident rise survives the ack.
    pending_d   = (pending_q & ~clr) | rise;
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;

    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d     = PRESENT;
          irq_valid_d = 1'b1;
          irq_id_d    = enc_id;
        end
      end
      PRESENT: begin
        if (bus.irq_ack) begin
          state_d     = IDLE;
          irq_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        irq_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d_q     <= '0;
      pending_q   <= '0;
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      req_d_q     <= req_d_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign bus.irq_valid = irq_valid_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed-vector bench for irq_pending_arbiter with hand-computed expectations.
module tb_irq_pending_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  irq_pending_arbiter_if bus ();

  irq_pending_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [2:0] id,
                            input logic [7:0] pend);
    check({tag, ".valid"}, {7'b0, bus.irq_valid}, {7'b0, v});
    if (v) check({tag, ".id"}, {5'b0, bus.irq_id}, {5'b0, id});
    check({tag, ".pending"}, bus.pending, pend);
  endtask

  logic [2:0] prio_ids  [5];
  logic [7:0] prio_pend [6];

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.mask    = '0;
    bus.irq_ack = 1'b0;
    prio_ids  = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    prio_pend = '{8'h3E, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00};

    repeat (2) tick();
    check("rst.valid", {7'b0, bus.irq_valid}, 8'h00);
    check("rst.id", {5'b0, bus.irq_id}, 8'h00);
    check("rst.pending", bus.pending, 8'h00);
    rst_n = 1'b1;
    tick();

    // Single request with latency and no re-request while held high.
    bus.req = 8'h08;
    tick();  expect_out("single.k", 1'b0, 3'd0, 8'h08);
    tick();  expect_out("single.k1", 1'b1, 3'd3, 8'h08);
    bus.irq_ack = 1'b1;
    tick();  expect_out("single.ack", 1'b0, 3'd0, 8'h00);
    bus.irq_ack = 1'b0;
    tick();  expect_out("single.held1", 1'b0, 3'd0, 8'h00);
    tick();  expect_out("single.held2", 1'b0, 3'd0, 8'h00);
    bus.req = 8'h00;
    tick();

    // Priority order over a multi-line rise.
    bus.req = 8'h3E;
    tick();  expect_out("prio.latch", 1'b0, 3'd0, 8'h3E);
    tick();
    for (int n = 0; n < 5; n++) begin
      expect_out($sformatf("prio.pres%0d", n), 1'b1, prio_ids[n], prio_pend[n]);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      expect_out($sformatf("prio.ack%0d", n), 1'b0, 3'd0, prio_pend[n+1]);
      tick();
    end
    expect_out("prio.done", 1'b0, 3'd0, 8'h00);
    bus.req = 8'h00;
    tick();

    // A higher-priority arrival does not pre-empt the presented ID.
    bus.req = 8'h04;
    tick();
    tick();  expect_out("hold.pres2", 1'b1, 3'd2, 8'h04);
    bus.req = 8'h84;
    tick();  expect_out("hold.raise7", 1'b1, 3'd2, 8'h84);
    tick();  expect_out("hold.still2", 1'b1, 3'd2, 8'h84);
    bus.irq_ack = 1'b1;
    tick();  expect_out("hold.ack2", 1'b0, 3'd0, 8'h80);
    bus.irq_ack = 1'b0;
    tick();  expect_out("hold.pres7", 1'b1, 3'd7, 8'h80);
    bus.irq_ack = 1'b1;
    tick();  expect_out("hold.ack7", 1'b0, 3'd0, 8'h00);
    bus.irq_ack = 1'b0;
    bus.req = 8'h00;
    tick();

    // Masking selects the lower line; masking the presented line keeps it up.
    bus.mask = 8'h80;
    bus.req  = 8'h81;
    tick();  expect_out("mask.latch", 1'b0, 3'd0, 8'h81);
    tick();  expect_out("mask.pres0", 1'b1, 3'd0, 8'h81);
    bus.irq_ack = 1'b1;
    tick();  expect_out("mask.ack0", 1'b0, 3'd0, 8'h80);
    bus.irq_ack = 1'b0;
    bus.mask = 8'h00;
    tick();  expect_out("mask.pres7", 1'b1, 3'd7, 8'h80);
    bus.mask = 8'h80;
    tick();  expect_out("mask.keep7", 1'b1, 3'd7, 8'h80);
    bus.irq_ack = 1'b1;
    tick();  expect_out("mask.ack7", 1'b0, 3'd0, 8'h00);
    bus.irq_ack = 1'b0;
    bus.mask = 8'h00;
    bus.req  = 8'h00;
    tick();

    // Ack while idle is ignored.
    bus.mask = 8'h01;
    bus.req  = 8'h01;
    tick();  expect_out("idleack.latch", 1'b0, 3'd0, 8'h01);
    bus.irq_ack = 1'b1;
    tick();  expect_out("idleack.ign", 1'b0, 3'd0, 8'h01);
    bus.irq_ack = 1'b0;
    bus.mask = 8'h00;
    tick();  expect_out("idleack.pres0", 1'b1, 3'd0, 8'h01);
    bus.irq_ack = 1'b1;
    tick();  expect_out("idleack.ack0", 1'b0, 3'd0, 8'h00);
    bus.irq_ack = 1'b0;
    bus.req = 8'h00;
    tick();

    // Set wins over clear on a coincident rise and ack.
    bus.req = 8'h10;
    tick();
    tick();  expect_out("coll.pres4", 1'b1, 3'd4, 8'h10);
    bus.req = 8'h00;
    tick();  expect_out("coll.drop", 1'b1, 3'd4, 8'h10);
    bus.req = 8'h10;
    bus.irq_ack = 1'b1;
    tick();  expect_out("coll.hit", 1'b0, 3'd0, 8'h10);
    bus.irq_ack = 1'b0;
    tick();  expect_out("coll.again4", 1'b1, 3'd4, 8'h10);
    bus.irq_ack = 1'b1;
    tick();  expect_out("coll.ack4", 1'b0, 3'd0, 8'h00);
    bus.irq_ack = 1'b0;
    bus.req = 8'h00;
    tick();

    // Asynchronous reset in the middle of a presentation.
    bus.req = 8'h02;
    tick();
    tick();  expect_out("arst.pres1", 1'b1, 3'd1, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", {7'b0, bus.irq_valid}, 8'h00);
    check("arst.id", {5'b0, bus.irq_id}, 8'h00);
    check("arst.pending", bus.pending, 8'h00);
    bus.req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();  expect_out("arst.rel1", 1'b0, 3'd0, 8'h00);
    tick();  expect_out("arst.rel2", 1'b0, 3'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_arbiter.md
# irq_pending_arbiter

Captures eight synchronous request lines as edge-triggered pending flags and applies a per-line mask. It selects the highest-priority unmasked pending line and presents its 3-bit index on a valid/ack handshake until the consumer accepts it. It sits directly upstream of the consumer of encoded request IDs and wraps the team's combinational 8-to-3 priority encoder with the state it lacks: latching, masking, holding and clearing.

## Interface
- `N_REQ`, 8: number of request lines. Fixed at 8 for this revision; other values are unsupported.
- `ID_W`, 3: index width, equal to log2(N_REQ).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request lines, synchronous to `clk`. A 0→1 transition raises a request.
- `mask`  in  8  1 blocks selection of that line; its pending flag is still kept.
- `irq_ack`  in  1  consumer accepts the presented ID.
- `irq_valid`  out  1  an ID is being presented.
- `irq_id`  out  3  index of the presented line; bit 7 is highest priority.
- `pending`  out  8  current pending flags, registered.

## Operation
- Edge detect:
  - `req_d` is `req` registered.
  - `rise = req & ~req_d`.
  - Each clock: `pending <= (pending & ~clr) | rise`.
- `clr` is a one-hot vector of `irq_id`, asserted only on an accepted handshake (`irq_valid & irq_ack`). Otherwise `clr` is zero.
- Set wins over clear. If a new rise on line n coincides with acceptance of ID n, `pending[n]` stays 1.
- Candidate vector: `cand = pending & ~mask`. The encoder returns the highest set index of `cand`, plus an any-set flag.
- State machine, 2 states:
  - IDLE: `irq_valid`=0. If `cand` is nonzero, register `irq_id` from the encoder, set `irq_valid`=1 and go to PRESENT.
  - PRESENT: `irq_valid`=1, and `irq_id` is held stable regardless of `req`, `mask` or `pending` changes. On `irq_ack`, clear `pending[irq_id]` and return to IDLE with `irq_valid`=0.
- Higher-priority arrivals never pre-empt a presented ID.
- `irq_ack` while in IDLE is ignored and has no effect on `pending`.
- Masking a line while its ID is presented does not withdraw the presentation. The consumer's ack clears it normally.
- Reset values:
  - `pending`=0, `req_d`=0, state=IDLE, `irq_valid`=0, `irq_id`=0.
  - A `req` line already high at reset release counts as a rising edge on the first clock.

## Timing
- Reset acts asynchronously on assertion. Release is taken synchronously at the next `clk` edge.
- Reset asserted mid-handshake drops `irq_valid` immediately and discards all pending flags.
- Latency, `req[n]` first sampled high at edge k:
  - `pending[n]`=1 after edge k.
  - `irq_valid`=1 after edge k+1, provided the block is in IDLE, line n is unmasked and n is the top candidate.
- Handshake accepted at edge a:
  - `irq_valid`=0 after edge a.
  - The earliest next presentation is after edge a+1, from the updated `pending`.
  - Back-to-back IDs are therefore separated by one idle cycle.
- `irq_valid` and `irq_id` are driven straight from registers, with no combinational path from inputs.
- A held-high `req` produces exactly one pending event. The line must go low and rise again to re-request.

## Structure
- Shared package `irq_pkg`:
  - `N_REQ` and `ID_W` constants.
  - State enum `{IDLE, PRESENT}`.
- Sub-module: reuse `priority_encoder_8to3`, with ports `i`/`out`/`valid` and highest index winning, instantiated on `cand`. All state lives in `irq_pending_arbiter`.

## Test plan
- Reset and single request:
  - `rst_n` low, then release.
  - `req`=8'b0000_1000 held, `mask`=0.
  - Expect `pending`=8'h08 one edge later and `irq_valid`=1, `irq_id`=3 the edge after.
  - Ack one cycle: `pending`=0, `irq_valid`=0, and no re-presentation while `req` stays high.
- Priority:
  - `req` rises to 8'b0011_1110 in one cycle.
  - Expect IDs 5, 4, 3, 2, 1 in that order, with ack each presentation.
  - `pending` reads 3E, 1E, 0E, 06, 02, 00.
- Hold without pre-emption:
  - While ID 2 is presented un-acked, raise `req[7]`.
  - `irq_id` stays 2 until ack, then 7 is presented next.
- Mask:
  - `mask`=8'h80, pending 8'h81: ID 0 is presented.
  - Clear the mask after the ack: ID 7 is presented.
  - Setting the mask on the presented line does not drop `irq_valid`.
- Set-vs-clear collision:
  - Line 4 presented.
  - Drop `req[4]` and re-raise it so its rise coincides with `irq_ack`.
  - Expect `pending[4]`=1 afterwards and ID 4 presented again.
- Async reset mid-handshake:
  - Assert `rst_n`=0 between clock edges while `irq_valid`=1.
  - Outputs go to 0 immediately. After release with `req`=0, no presentation occurs.
